// File: rtl/sync_pulse_arb.sv
// Round-robin arbiter sharing one four-phase request/ack crossing among N pulse sources.
// Optional watchdog enabled by defining SYNC_ARB_TIMEOUT_EN.
module sync_pulse_arb #(
  parameter int unsigned N           = 4,
  parameter int unsigned ID_W        = 2,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic            clka,
  input  logic            rst_n,
  input  logic [N-1:0]    pulse_in,
  input  logic            sync_ack,
  input  logic            err_clr,
  output logic            sync_req,
  output logic [ID_W-1:0] sync_id,
  output logic            busy,
  output logic [N-1:0]    pend,
  output logic [N-1:0]    done_pulse,
  output logic [N-1:0]    drop_err,
  output logic            timeout_err
);

  typedef enum logic [1:0] {StIdle, StReq, StRelease} state_e;
  state_e state_q, state_d;

  logic            ack_meta_q, ack_s_q;
  logic [ID_W-1:0] ptr_q, ptr_d, id_q, id_d, gnt_idx;
  logic            req_q, req_d, busy_q, busy_d;
  logic            found, grant, tmo_hit, abort, done_ok;
  logic [N-1:0]    pend_q, pend_d, done_q, done_d, drop_q, drop_d, grant_oh;

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      ack_meta_q <= 1'b0;
      ack_s_q    <= 1'b0;
      ptr_q      <= '0;
      id_q       <= '0;
      req_q      <= 1'b0;
      busy_q     <= 1'b0;
      pend_q     <= '0;
      done_q     <= '0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      ack_meta_q <= sync_ack;
      ack_s_q    <= ack_meta_q;
      ptr_q      <= ptr_d;
      id_q       <= id_d;
      req_q      <= req_d;
      busy_q     <= busy_d;
      pend_q     <= pend_d;
      done_q     <= done_d;
      drop_q     <= drop_d;
    end
  end

  // First pending index at or above the pointer wins; otherwise wrap to the lowest pending one.
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!found && pend_q[i] && (ID_W'(i) >= ptr_q)) begin
        found   = 1'b1;
        gnt_idx = ID_W'(i);
      end
    end
    for (int unsigned i = 0; i < N; i++) begin
      if (!found && pend_q[i]) begin
        found   = 1'b1;
        gnt_idx = ID_W'(i);
      end
    end
  end

  // Holding off while ack_s is high keeps a new request from rising into a stale ack.
  assign grant   = (state_q == StIdle) && found && !ack_s_q;
  assign done_ok = !ack_s_q && !abort;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (grant) state_d = StReq;
      StReq:     if (ack_s_q || tmo_hit) state_d = StRelease;
      StRelease: if (done_ok || tmo_hit) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    grant_oh = grant ? (N'(1) << gnt_idx) : '0;
    pend_d   = (pend_q & ~grant_oh) | pulse_in;
    drop_d   = (err_clr ? '0 : drop_q) | (pulse_in & pend_q & ~grant_oh);
    ptr_d    = ptr_q;
    id_d     = id_q;
    req_d    = req_q;
    busy_d   = busy_q;
    done_d   = '0;
    if (grant) begin
      ptr_d  = (32'(gnt_idx) == N - 1) ? '0 : gnt_idx + 1'b1;
      id_d   = gnt_idx;
      req_d  = 1'b1;
      busy_d = 1'b1;
    end
    if (state_q == StReq && state_d == StRelease) req_d = 1'b0;
    if (state_q == StRelease && state_d == StIdle) begin
      busy_d = 1'b0;
      if (done_ok) done_d = N'(1) << id_q;
    end
  end

`ifdef SYNC_ARB_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            abort_q, abort_d, tmo_err_q, tmo_err_d;

  assign tmo_hit = (state_q != StIdle) && (cnt_q == CntW'(TIMEOUT_CYC - 1));

  // After a REQ timeout the release phase runs out its own timer instead of trusting ack.
  always_comb begin
    cnt_d   = ((state_q == StIdle) || (state_d != state_q)) ? '0 : cnt_q + 1'b1;
    abort_d = abort_q;
    if (state_q == StReq && state_d == StRelease) abort_d = !ack_s_q;
    else if (state_d == StIdle)                    abort_d = 1'b0;
    tmo_err_d = (err_clr ? 1'b0 : tmo_err_q) |
                (tmo_hit && !((state_q == StReq) ? ack_s_q : done_ok));
  end

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      abort_q   <= 1'b0;
      tmo_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      abort_q   <= abort_d;
      tmo_err_q <= tmo_err_d;
    end
  end

  assign abort       = abort_q;
  assign timeout_err = tmo_err_q;
`else
  // Parameter still referenced so the disabled build elaborates without unused warnings.
  assign tmo_hit     = 1'b0 & (TIMEOUT_CYC == 0);
  assign abort       = 1'b0;
  assign timeout_err = 1'b0;
`endif

  assign sync_req   = req_q;
  assign sync_id    = id_q;
  assign busy       = busy_q;
  assign pend       = pend_q;
  assign done_pulse = done_q;
  assign drop_err   = drop_q;

endmodule
